// File: rtl/alu_seq_if.sv
// Shared types for the nibble ALU plus the request/result bus of alu_seq.
// The 4-bit ALU sits outside alu_seq so that several sequencers can share one.
package alu_seq_pkg;
    typedef struct packed {
        logic       carry_in;
        logic       b_inv;
        logic       carry_disable;
        logic [1:0] cmd;
    } alu_ctrl_t;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        alu_ctrl_t  ctrl;
    } alu_args_t;

    typedef struct packed {
        logic [3:0] result;
        logic       carry_out;
    } alu_ret_t;
endpackage

interface alu_seq_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         eq;
    logic         zero;

    modport master (output start, op, a, b, input ready, done, result, carry, eq, zero);
    modport slave  (input start, op, a, b, output ready, done, result, carry, eq, zero);
endinterface

// File: rtl/alu_seq.sv
// Runs one W-bit operation as NIBBLES passes through a shared 4-bit ALU, LSB nibble first.
// Published flags/result only change on the DONE transition, so they hold across later runs.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus,
    output alu_args_t alu_args,
    input  alu_ret_t  alu_ret
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_COMP  = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_XNOR  = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;
    localparam logic [2:0] OP_OR    = 3'd6;
    localparam logic [2:0] OP_RSHFT = 3'd7;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          cy_q, cy_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_q, carry_d, eq_q, eq_d, zero_q, zero_d;
    logic [W-1:0]  b_hi;
    logic          first;

    // Bit 3 of each nibble of b_hi is the bit shifted into that nibble's MSB.
    assign b_hi  = b_q >> 1;
    assign first = (idx_q == '0);

    always_comb begin
        alu_args = '0;
        if (state_q == S_RUN) begin
            alu_args.d1 = a_q[4*int'(idx_q) +: 4];
            alu_args.d2 = b_q[4*int'(idx_q) +: 4];
            case (op_q)
                OP_ADD: begin
                    {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b0000;
                    alu_args.ctrl.carry_in = first ? 1'b0 : cy_q;
                end
                OP_SUB: begin
                    {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b1000;
                    alu_args.ctrl.carry_in = first ? 1'b1 : cy_q;
                end
                OP_COMP: begin
                    {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b1000;
                    alu_args.ctrl.carry_in = first ? 1'b0 : cy_q;
                end
                OP_XOR:  {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b0100;
                OP_XNOR: {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b1100;
                OP_AND:  {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b0101;
                OP_OR:   {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b0110;
                default: begin
                    {alu_args.ctrl.b_inv, alu_args.ctrl.carry_disable, alu_args.ctrl.cmd} = 4'b0111;
                    alu_args.ctrl.carry_in = b_hi[4*int'(idx_q) + 3];
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        eq_d     = eq_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
            end
            S_RUN: begin
                work_d[4*int'(idx_q) +: 4] = alu_ret.result;
                cy_d = alu_ret.carry_out;
                if (idx_q == IDX_LAST) begin
                    state_d  = S_DONE;
                    result_d = work_d;
                    zero_d   = (work_d == '0);
                    eq_d     = (op_q == OP_COMP) && (&work_d);
                    case (op_q)
                        OP_ADD, OP_SUB, OP_COMP: carry_d = alu_ret.carry_out;
                        OP_RSHFT:                carry_d = b_q[0];
                        default:                 carry_d = 1'b0;
                    endcase
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            eq_q     <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.eq     = eq_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: word-level reference model, nibble ALU model, random + directed ops.
module tb_alu_seq;
    import alu_seq_pkg::*;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         e;
        logic         z;
        int           k;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    alu_args_t alu_args;
    alu_ret_t  alu_ret;
    alu_seq_if #(.NIBBLES(N)) bus();

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t held;

    alu_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .alu_args(alu_args), .alu_ret(alu_ret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU that the sequencer drives.
    logic [3:0] bx;
    logic [4:0] sum;
    always_comb begin
        bx  = alu_args.ctrl.b_inv ? ~alu_args.d2 : alu_args.d2;
        sum = {1'b0, alu_args.d1} + {1'b0, bx} + {4'b0, alu_args.ctrl.carry_in};
        alu_ret = '0;
        case (alu_args.ctrl.cmd)
            2'b00: begin
                if (alu_args.ctrl.carry_disable) alu_ret.result = alu_args.d1 ^ bx;
                else begin
                    alu_ret.result    = sum[3:0];
                    alu_ret.carry_out = sum[4];
                end
            end
            2'b01: alu_ret.result = alu_args.d1 & bx;
            2'b10: alu_ret.result = alu_args.d1 | bx;
            default: begin
                alu_ret.result    = {alu_args.ctrl.carry_in, alu_args.d2[3:1]};
                alu_ret.carry_out = alu_args.d2[0];
            end
        endcase
    end

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e.c = 1'b0; e.e = 1'b0; e.k = 0; e.op = op; e.a = a; e.b = b;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; e.r = s[W-1:0]; e.c = s[W]; end
            3'd1: begin e.r = a - b; e.c = (a >= b); end
            3'd2: begin e.r = a + ~b; e.c = (a > b); e.e = (a == b); end
            3'd3: e.r = a ^ b;
            3'd4: e.r = ~(a ^ b);
            3'd5: e.r = a & b;
            3'd6: e.r = a | b;
            default: begin e.r = b >> 1; e.c = b[0]; end
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Monitor: pops on done, otherwise requires outputs to hold the last published values.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            held.r = '0; held.c = 1'b0; held.e = 1'b0; held.z = 1'b1;
        end else if (bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.result !== e.r || bus.carry !== e.c || bus.eq !== e.e || bus.zero !== e.z
                    || cyc != e.k + N) begin
                    errors++;
                    $display("FAIL result op=%0d a=%h b=%h: got r=%h c=%b eq=%b z=%b lat=%0d, want r=%h c=%b eq=%b z=%b lat=%0d",
                             e.op, e.a, e.b, bus.result, bus.carry, bus.eq, bus.zero, cyc - e.k,
                             e.r, e.c, e.e, e.z, N);
                end
                held = e;
            end
        end else begin
            checks++;
            if (bus.result !== held.r || bus.carry !== held.c || bus.eq !== held.e || bus.zero !== held.z) begin
                errors++;
                $display("FAIL hold at cycle %0d: got r=%h c=%b eq=%b z=%b, want r=%h c=%b eq=%b z=%b",
                         cyc, bus.result, bus.carry, bus.eq, bus.zero, held.r, held.c, held.e, held.z);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0
            || bus.eq !== 1'b0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL %s: got rdy=%b done=%b r=%h c=%b eq=%b z=%b, want rdy=1 done=0 r=0 c=0 eq=0 z=1",
                     tag, bus.ready, bus.done, bus.result, bus.carry, bus.eq, bus.zero);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb);
        exp_t e;
        int   n = 0;
        while (!bus.ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, want 1", bus.ready, n);
            return;
        end
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        e = model(op, a, b);
        e.k = cyc;
        exp_q.push_back(e);
        bus.op = 3'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
        bus.start = disturb;
        if (disturb) begin
            repeat (2) @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    logic [2:0]   d_op [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd7, 3'd3, 3'd5, 3'd6, 3'd4};
    logic [W-1:0] d_a  [12] = '{16'h0FFF, 16'hFFFF, 16'h1000, 16'h0000, 16'h1234, 16'h1235, 16'h1233,
                                16'h0000, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0};
    logic [W-1:0] d_b  [12] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h1234, 16'h1234,
                                16'h8001, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};

    initial begin
        logic [W-1:0] ra, rb;
        int           n;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 1'b0);
        issue(3'd0, 16'h1111, 16'h2222, 1'b1);
        issue(3'd1, 16'h0005, 16'h0007, 1'b1);

        // Abort in the second RUN cycle, then a fresh ADD must run normally.
        issue(3'd0, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(3'd0, 16'h0001, 16'h0001, 1'b0);

        for (int i = 0; i < 80; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = '0;
                2: rb = '1;
                default: ;
            endcase
            issue(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operation; the operand width is W = 4*NIBBLES.
REQ-002 Port: clk  in  1  the single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: start  in  1  request to begin an operation; accepted only when ready=1.
REQ-005 Port: op  in  3  operation code: 0 ADD, 1 SUB, 2 COMP, 3 XOR, 4 XNOR, 5 AND, 6 OR, 7 RSHFT.
REQ-006 Port: a  in  W  operand A; sampled on accept.
REQ-007 Port: b  in  W  operand B; sampled on accept.
REQ-008 Port: alu_args  out  AluArgs  drives the shared 4-bit alu instance (d1, d2, ctrl).
REQ-009 Port: alu_ret  in  AluRet  result and carry_out returned by the alu instance.
REQ-010 Port: ready  out  1  high in IDLE only.
REQ-011 Port: done  out  1  one-cycle pulse marking valid results.
REQ-012 Port: result  out  W  assembled result.
REQ-013 Port: carry  out  1  final carry flag; meaning depends on op (see REQ-023).
REQ-014 Port: eq  out  1  COMP equality flag.
REQ-015 Port: zero  out  1  result == 0.

Function
REQ-016 State machine SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start=1; a, b and op are registered and the nibble index idx is cleared to 0.
- RUN->RUN while idx < NIBBLES-1, incrementing idx.
- RUN->DONE when idx = NIBBLES-1.
- DONE->IDLE unconditionally.
REQ-017 In RUN, alu_args.d1/d2 SHALL be nibble idx of the registered A/B, processing LSB nibble first, one nibble per cycle; alu_ret is captured into result nibble idx on the same edge.
REQ-018 The ALU ctrl low 4 bits {b_inv, carry_disable, cmd} SHALL be:
- ADD 0000, SUB 1000, COMP 1000;
- XOR 0100, XNOR 1100, AND 0101, OR 0110, RSHFT 0111.
REQ-019 ctrl.carry_in SHALL be:
- ADD: 0 at idx 0, then the registered carry from the previous nibble.
- SUB: 1 at idx 0, then the previous carry.
- COMP: 0 at idx 0, then the previous carry.
- RSHFT: b[4*(idx+1)], or 0 for the top nibble.
- Logic ops: 0.
REQ-020 The inter-nibble carry register SHALL load alu_ret.carry_out on every RUN cycle.
REQ-021 Outside RUN, alu_args SHALL be driven all-zero (ADD of 0,0).
REQ-022 Latency: with accept at edge k, done=1 in the cycle after edge k+NIBBLES, i.e. NIBBLES+1 cycles after accept; ready returns 1 one cycle after done.
REQ-023 Carry SHALL be:
- ADD: unsigned overflow.
- SUB: 1 = no borrow (A>=B).
- COMP: 1 = A>B.
- RSHFT: registered b[0] (the bit shifted out).
- Logic ops: 0.
REQ-024 eq SHALL be 1 only for COMP when every nibble result equals 4'hF (A==B); for all other ops eq=0.
REQ-025 result, carry, eq and zero SHALL be stable from the done cycle until the next accept, and SHALL NOT change during RUN of a later operation until that operation's done.
REQ-026 start while ready=0 SHALL be ignored; it is neither queued nor aborts the current operation.
REQ-027 Operand changes on a/b/op after accept SHALL NOT affect the operation in progress.
REQ-028 All arithmetic SHALL be modulo 2^W; for all ops there is no sign interpretation.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, idx=0, ready=1, done=0, result=0, carry=0, eq=0, zero=1, and the internal carry and operand registers are 0.
REQ-030 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; after release the block is ready and the first start SHALL run normally.

Verification (NIBBLES=4)
REQ-031 ADD a=16'h0FFF b=16'h0001 -> result 16'h1000, carry 0, zero 0, done exactly 5 cycles after accept; ADD 16'hFFFF+16'h0001 -> result 0, carry 1, zero 1.
REQ-032 SUB 16'h1000-16'h0001 -> 16'h0FFF, carry 1; SUB 16'h0000-16'h0001 -> 16'hFFFF, carry 0.
REQ-033 COMP 16'h1234 vs 16'h1234 -> eq 1, carry 0; 16'h1235 vs 16'h1234 -> eq 0, carry 1; 16'h1233 vs 16'h1234 -> eq 0, carry 0.
REQ-034 RSHFT b=16'h8001 -> result 16'h4000, carry 1; XOR 16'hF0F0^16'hFF00 -> 16'h0FF0; AND/OR/XNOR of the same operands match the bitwise reference.
REQ-035 Start pulse with different operands during RUN -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-036 rst_n low at the second RUN cycle -> all outputs at reset values immediately, no done pulse; a following ADD 1+1 -> result 2.
